// File: rtl/rst_seq_if.sv
// Control and status bundle between the reset sequencer and its CSR/watchdog client.
// The client (master) drives the requests; the sequencer (slave) drives the resets and status.
interface rst_seq_if;
    logic       i_sw_rst_req;
    logic       i_wdt_en;
    logic       i_wdt_kick;
    logic       o_rst_mem;
    logic       o_rst_periph;
    logic       o_rst_cpu;
    logic       o_ready;
    logic [1:0] o_rst_cause;
    logic [7:0] o_warm_cnt;

    modport master (
        output i_sw_rst_req, i_wdt_en, i_wdt_kick,
        input  o_rst_mem, o_rst_periph, o_rst_cpu, o_ready, o_rst_cause, o_warm_cnt
    );

    modport slave (
        input  i_sw_rst_req, i_wdt_en, i_wdt_kick,
        output o_rst_mem, o_rst_periph, o_rst_cpu, o_ready, o_rst_cause, o_warm_cnt
    );
endinterface

// File: rtl/rst_seq.sv
// Staged reset release (memory, then peripherals, then CPU) with a watchdog and a
// software warm-reset path; every output is a flop loaded from the next-state decode.
module rst_seq #(
    parameter int unsigned STAGE_CYCLES = 16,
    parameter int unsigned WDT_CYCLES   = 25000000
) (
    input  logic     i_clk,
    input  logic     i_rst,
    rst_seq_if.slave bus
);
    localparam int SW = $clog2(STAGE_CYCLES);
    localparam int WW = $clog2(WDT_CYCLES);
    localparam logic [SW-1:0] STAGE_LAST = SW'(STAGE_CYCLES - 1);
    localparam logic [WW-1:0] WDT_LAST   = WW'(WDT_CYCLES - 1);

    localparam logic [1:0] CAUSE_POR = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;
    localparam logic [1:0] CAUSE_WDT = 2'b11;

    typedef enum logic [1:0] {S_HOLD, S_MEM, S_PERIPH, S_RUN} state_t;

    state_t        r_state, w_state_nxt;
    logic [SW-1:0] r_stage_cnt, w_stage_cnt_nxt;
    logic [WW-1:0] r_wdt_cnt, w_wdt_cnt_nxt;
    logic [1:0]    r_cause, w_cause_nxt;
    logic [7:0]    r_warm_cnt, w_warm_cnt_nxt;
    logic          r_rst_mem, r_rst_periph, r_rst_cpu, r_ready;
    logic          w_stage_done, w_wdt_expire;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign w_stage_done = (r_stage_cnt == STAGE_LAST);
    // Kick or disable in the expiry cycle pre-empts the timeout.
    assign w_wdt_expire = bus.i_wdt_en && !bus.i_wdt_kick && (r_wdt_cnt == WDT_LAST);

    always_comb begin
        w_state_nxt     = r_state;
        w_stage_cnt_nxt = '0;
        w_wdt_cnt_nxt   = '0;
        w_cause_nxt     = r_cause;
        w_warm_cnt_nxt  = r_warm_cnt;
        case (r_state)
            S_HOLD: begin
                w_stage_cnt_nxt = w_stage_done ? '0 : r_stage_cnt + SW'(1);
                if (w_stage_done) w_state_nxt = S_MEM;
            end
            S_MEM: begin
                w_stage_cnt_nxt = w_stage_done ? '0 : r_stage_cnt + SW'(1);
                if (w_stage_done) w_state_nxt = S_PERIPH;
            end
            S_PERIPH: begin
                w_stage_cnt_nxt = w_stage_done ? '0 : r_stage_cnt + SW'(1);
                if (w_stage_done) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (bus.i_sw_rst_req) begin
                    w_state_nxt    = S_HOLD;
                    w_cause_nxt    = CAUSE_SW;
                    w_warm_cnt_nxt = sat_inc8(r_warm_cnt);
                end else if (w_wdt_expire) begin
                    w_state_nxt    = S_HOLD;
                    w_cause_nxt    = CAUSE_WDT;
                    w_warm_cnt_nxt = sat_inc8(r_warm_cnt);
                end else if (bus.i_wdt_en && !bus.i_wdt_kick) begin
                    w_wdt_cnt_nxt = r_wdt_cnt + WW'(1);
                end
            end
            default: w_state_nxt = S_HOLD;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_HOLD;
            r_stage_cnt <= '0;
            r_wdt_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_stage_cnt <= w_stage_cnt_nxt;
            r_wdt_cnt   <= w_wdt_cnt_nxt;
        end
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rst_mem    <= 1'b1;
            r_rst_periph <= 1'b1;
            r_rst_cpu    <= 1'b1;
            r_ready      <= 1'b0;
            r_cause      <= CAUSE_POR;
            r_warm_cnt   <= 8'd0;
        end else begin
            r_rst_mem    <= (w_state_nxt == S_HOLD);
            r_rst_periph <= (w_state_nxt == S_HOLD) || (w_state_nxt == S_MEM);
            r_rst_cpu    <= (w_state_nxt != S_RUN);
            r_ready      <= (w_state_nxt == S_RUN);
            r_cause      <= w_cause_nxt;
            r_warm_cnt   <= w_warm_cnt_nxt;
        end
    end

    assign bus.o_rst_mem    = r_rst_mem;
    assign bus.o_rst_periph = r_rst_periph;
    assign bus.o_rst_cpu    = r_rst_cpu;
    assign bus.o_ready      = r_ready;
    assign bus.o_rst_cause  = r_cause;
    assign bus.o_warm_cnt   = r_warm_cnt;
endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq: directed scenarios plus random traffic, compared
// each cycle against a timeline model (cycles since sequence start, idle cycles in RUN).
module tb_rst_seq;
    localparam int S = 4;
    localparam int W = 10;

    logic clk = 1'b0;
    logic rst;

    rst_seq_if bus ();

    rst_seq #(.STAGE_CYCLES(S), .WDT_CYCLES(W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference: m_t = clock edges since the release sequence (re)started, m_idle = unserviced RUN cycles.
    int m_t, m_idle, m_cause, m_warm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_idle = 0; m_cause = 1; m_warm = 0;
    endtask

    task automatic model_restart(input int cause);
        m_t = 0; m_idle = 0; m_cause = cause;
        if (m_warm < 255) m_warm++;
    endtask

    task automatic model_step(input bit sw, input bit en, input bit kick);
        if (m_t >= 3*S) begin
            if (sw)                                    model_restart(2);
            else if (en && !kick && m_idle == W-1)     model_restart(3);
            else if (!en || kick)                      m_idle = 0;
            else                                       m_idle++;
        end else begin
            m_t++;
            m_idle = 0;
        end
    endtask

    task automatic check_outs();
        chk("rst_mem",    bus.o_rst_mem,    m_t < S);
        chk("rst_periph", bus.o_rst_periph, m_t < 2*S);
        chk("rst_cpu",    bus.o_rst_cpu,    m_t < 3*S);
        chk("ready",      bus.o_ready,      m_t >= 3*S);
        chk("cause",      bus.o_rst_cause,  m_cause);
        chk("warm_cnt",   bus.o_warm_cnt,   m_warm);
    endtask

    // One clock: drive inputs, advance the model on the edge, check just after it.
    task automatic cycle(input bit sw, input bit en, input bit kick);
        bus.i_sw_rst_req = sw;
        bus.i_wdt_en     = en;
        bus.i_wdt_kick   = kick;
        @(posedge clk);
        model_step(sw, en, kick);
        #1;
        check_outs();
        @(negedge clk);
        bus.i_sw_rst_req = 1'b0;
        bus.i_wdt_kick   = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.i_sw_rst_req = 1'b0;
        bus.i_wdt_en     = 1'b0;
        bus.i_wdt_kick   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outs();
        rst = 1'b0;

        // Cold boot release
        repeat (12) cycle(0, 0, 0);
        chk("cold_ready", bus.o_ready, 1);
        chk("cold_cause", bus.o_rst_cause, 1);

        // Watchdog expiry with no service
        repeat (10) cycle(0, 1, 0);
        chk("wdt_cause", bus.o_rst_cause, 3);
        chk("wdt_warm",  bus.o_warm_cnt, 1);
        chk("wdt_hold",  bus.o_rst_cpu, 1);
        repeat (12) cycle(0, 1, 0);
        chk("wdt_rerelease", bus.o_ready, 1);

        // Regular kicks every 9 cycles, then a kick exactly on the expiry cycle
        cycle(0, 0, 0);
        for (int i = 0; i < 200; i++) cycle(0, 1, (i % 9) == 8);
        chk("kick9_ready", bus.o_ready, 1);
        chk("kick9_warm",  bus.o_warm_cnt, 1);
        cycle(0, 0, 0);
        repeat (9) cycle(0, 1, 0);
        cycle(0, 1, 1);
        chk("kick_edge_ready", bus.o_ready, 1);
        chk("kick_edge_warm",  bus.o_warm_cnt, 1);

        // Software request coincident with expiry, then a request during PERIPH
        cycle(0, 0, 0);
        repeat (9) cycle(0, 1, 0);
        cycle(1, 1, 0);
        chk("sw_wdt_cause", bus.o_rst_cause, 2);
        chk("sw_wdt_warm",  bus.o_warm_cnt, 2);
        repeat (9) cycle(0, 0, 0);
        cycle(1, 0, 0);
        repeat (2) cycle(0, 0, 0);
        chk("periph_sw_ready", bus.o_ready, 1);
        chk("periph_sw_warm",  bus.o_warm_cnt, 2);

        // Random traffic
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0);

        // Saturation of the warm-reset counter
        for (int k = 0; k < 260; k++) begin
            while (m_t < 3*S) cycle(0, 0, 0);
            cycle(1, 0, 0);
        end
        chk("warm_sat", bus.o_warm_cnt, 255);

        // Asynchronous reset mid-MEM, away from any clock edge
        repeat (S + 1) cycle(0, 0, 0);
        chk("pre_rst_mem", bus.o_rst_mem, 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_mem",    bus.o_rst_mem, 1);
        chk("async_periph", bus.o_rst_periph, 1);
        chk("async_cpu",    bus.o_rst_cpu, 1);
        chk("async_ready",  bus.o_ready, 0);
        chk("async_cause",  bus.o_rst_cause, 1);
        chk("async_warm",   bus.o_warm_cnt, 0);
        @(posedge clk);
        #1;
        check_outs();
        @(negedge clk);
        rst = 1'b0;
        repeat (12) cycle(0, 0, 0);
        chk("post_rst_ready", bus.o_ready, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
